// File: rtl/bus_pkg.sv
// Shared bus definitions for the endpoint slice.
// Contents:
//   ID_W          - width of the destination-ID field at the top of a packet
//   BROADCAST_ID  - destination ID that every endpoint accepts
//   PKT_MAX_W     - widest packet the dest_id() helper can take
//   ERR_POP_EMPTY - err bit index: bus popped an empty TX FIFO
//   ERR_MISROUTE  - err bit index: bus pushed a packet for another ID
//   dest_id()     - extracts the destination ID from a packet of a given width
package bus_pkg;

   localparam int unsigned ID_W          = 8;
   localparam logic [7:0]  BROADCAST_ID  = 8'hFF;
   localparam int unsigned PKT_MAX_W     = 256;
   localparam int unsigned ERR_POP_EMPTY = 0;
   localparam int unsigned ERR_MISROUTE  = 1;

   // The packet is zero-extended into PKT_MAX_W bits by the caller; the ID
   // is the top ID_W bits of the original width.
   function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned width);
      return ID_W'(pkt >> (width - ID_W));
   endfunction

endpackage

// File: rtl/bus_endpoint_if.sv
// Host/bus signal bundle of bus_endpoint.
// Host side : tx_valid, tx_data, tx_ready, rx_valid, rx_data, rx_ready
// Bus side  : pndng, D_pop, pop, push, D_push
// Status    : tx_count, rx_count, ovf_cnt, err
// Modports  : slave  - the endpoint itself
//             master - whatever drives the endpoint (host + bus)
interface bus_endpoint_if #(
   parameter int unsigned pckg_sz = 16,
   parameter int unsigned depth   = 8
);
   localparam int unsigned CW = $clog2(depth) + 1;

   logic               tx_valid;
   logic [pckg_sz-1:0] tx_data;
   logic               tx_ready;
   logic               pndng;
   logic [pckg_sz-1:0] D_pop;
   logic               pop;
   logic               push;
   logic [pckg_sz-1:0] D_push;
   logic               rx_valid;
   logic [pckg_sz-1:0] rx_data;
   logic               rx_ready;
   logic [CW-1:0]      tx_count;
   logic [CW-1:0]      rx_count;
   logic [7:0]         ovf_cnt;
   logic [1:0]         err;

   modport slave (
      input  tx_valid, tx_data, pop, push, D_push, rx_ready,
      output tx_ready, pndng, D_pop, rx_valid, rx_data,
             tx_count, rx_count, ovf_cnt, err
   );

   modport master (
      output tx_valid, tx_data, pop, push, D_push, rx_ready,
      input  tx_ready, pndng, D_pop, rx_valid, rx_data,
             tx_count, rx_count, ovf_cnt, err
   );

endinterface

// File: rtl/bus_endpoint_fifo.sv
// ep_fifo: first-word-fall-through FIFO used for both endpoint directions.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   wr, wdata    - write request and data; taken when not full, or when
//                  full but a read happens in the same cycle
//   rd, rdata    - read request and FWFT head; rd while empty is ignored
//   count        - occupancy 0..depth
//   full, empty  - decoded from count
module ep_fifo #(
   parameter int unsigned width = 16,
   parameter int unsigned depth = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr,
   input  logic [width-1:0]           wdata,
   input  logic                       rd,
   output logic [width-1:0]           rdata,
   output logic [$clog2(depth):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int unsigned PW = $clog2(depth);

   logic [width-1:0] mem [depth];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_rd;
   logic             do_wr;

   assign full  = (count == (PW+1)'(depth));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   assign do_rd = rd & ~empty;
   assign do_wr = wr & (~full | do_rd);

   // Pointers wrap naturally: depth is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (do_rd) rd_ptr <= rd_ptr + PW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/bus_endpoint.sv
// bus_endpoint: bus endpoint with a TX FIFO (host -> bus) and an RX FIFO
// (bus -> host) filtered on destination ID.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bif   - bus_endpoint_if slave modport: host TX/RX handshakes, bus
//           pop/push side, occupancy counts, overflow counter, sticky errors
module bus_endpoint
   import bus_pkg::*;
#(
   parameter int unsigned     pckg_sz   = 16,
   parameter int unsigned     depth     = 8,
   parameter logic [ID_W-1:0] id        = '0,
   parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
   input  logic           clk,
   input  logic           reset,
   bus_endpoint_if.slave  bif
);
   logic            tx_full, tx_empty, rx_full, rx_empty;
   logic            tx_wr, tx_rd, rx_wr, rx_rd;
   logic            dest_ok, rx_drop;
   logic [ID_W-1:0] dest;

   assign dest    = dest_id(PKT_MAX_W'(bif.D_push), pckg_sz);
   assign dest_ok = (dest == id) || (dest == broadcast);

   assign tx_wr   = bif.tx_valid & ~tx_full;
   assign tx_rd   = bif.pop & ~tx_empty;
   assign rx_rd   = bif.rx_ready & ~rx_empty;
   // A full RX FIFO still accepts when the host drains the head this cycle.
   assign rx_wr   = bif.push & dest_ok & (~rx_full | rx_rd);
   assign rx_drop = bif.push & dest_ok & rx_full & ~bif.rx_ready;

   assign bif.tx_ready = ~tx_full;
   assign bif.pndng    = ~tx_empty;
   assign bif.rx_valid = ~rx_empty;

   ep_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (tx_wr),
      .wdata (bif.tx_data),
      .rd    (tx_rd),
      .rdata (bif.D_pop),
      .count (bif.tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   ep_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (rx_wr),
      .wdata (bif.D_push),
      .rd    (rx_rd),
      .rdata (bif.rx_data),
      .count (bif.rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bif.err     <= '0;
         bif.ovf_cnt <= '0;
      end else begin
         if (bif.pop && tx_empty)     bif.err[ERR_POP_EMPTY] <= 1'b1;
         if (bif.push && !dest_ok)    bif.err[ERR_MISROUTE]  <= 1'b1;
         if (rx_drop && bif.ovf_cnt != 8'hFF) bif.ovf_cnt <= bif.ovf_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_bus_endpoint.sv
// Directed self-checking bench for bus_endpoint (id=2, depth=8, 16-bit packets).
module tb_bus_endpoint;

   logic clk = 1'b0;
   logic reset;
   int   vectors    = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   bus_endpoint_if #(.pckg_sz(16), .depth(8)) bif ();

   bus_endpoint #(.pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)) dut (
      .clk   (clk),
      .reset (reset),
      .bif   (bif)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] q[$];
   logic [15:0] d;
   logic        accept;
   int          writes;

   initial begin
      reset        = 1'b0;
      bif.tx_valid = 1'b0;
      bif.tx_data  = '0;
      bif.pop      = 1'b0;
      bif.push     = 1'b0;
      bif.D_push   = '0;
      bif.rx_ready = 1'b0;
      #2;
      check("rst_tx_ready", 16'(bif.tx_ready), 16'd1);
      check("rst_pndng",    16'(bif.pndng),    16'd0);
      check("rst_rx_valid", 16'(bif.rx_valid), 16'd0);
      check("rst_tx_count", 16'(bif.tx_count), 16'd0);
      check("rst_rx_count", 16'(bif.rx_count), 16'd0);
      check("rst_ovf",      16'(bif.ovf_cnt),  16'd0);
      check("rst_err",      16'(bif.err),      16'd0);
      #20;
      reset = 1'b1;
      tick();

      // Three TX writes, then three bus pops.
      bif.tx_valid = 1'b1;
      bif.tx_data = 16'h0201; tick();
      check("tx_lat_1", bif.D_pop, 16'h0201);
      bif.tx_data = 16'h0302; tick();
      bif.tx_data = 16'h0403; tick();
      bif.tx_valid = 1'b0;
      check("tx3_pndng", 16'(bif.pndng),    16'd1);
      check("tx3_dpop",  bif.D_pop,         16'h0201);
      check("tx3_count", 16'(bif.tx_count), 16'd3);
      bif.pop = 1'b1;
      tick(); check("pop1_dpop", bif.D_pop, 16'h0302);
      tick(); check("pop2_dpop", bif.D_pop, 16'h0403);
      tick();
      bif.pop = 1'b0;
      check("pop3_pndng", 16'(bif.pndng),    16'd0);
      check("pop3_count", 16'(bif.tx_count), 16'd0);
      check("pop3_err",   16'(bif.err),      16'd0);

      // ID filter: own ID, broadcast, foreign ID.
      bif.push = 1'b1;
      bif.D_push = 16'h02AA; tick();
      bif.D_push = 16'hFF55; tick();
      bif.D_push = 16'h0311; tick();
      bif.push = 1'b0;
      check("flt_rx_count", 16'(bif.rx_count), 16'd2);
      check("flt_err",      16'(bif.err),      16'b10);
      check("flt_rx_data",  bif.rx_data,       16'h02AA);
      check("flt_rx_valid", 16'(bif.rx_valid), 16'd1);
      bif.rx_ready = 1'b1;
      tick(); check("drain1_data", bif.rx_data, 16'hFF55);
      tick(); check("drain2_cnt",  16'(bif.rx_count), 16'd0);
      tick(); // rx_ready while empty: ignored, no flag
      bif.rx_ready = 1'b0;
      check("rdempty_cnt", 16'(bif.rx_count), 16'd0);
      check("rdempty_err", 16'(bif.err),      16'b10);

      // Nine accepted pushes into an 8-deep FIFO with no host reads.
      bif.push = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bif.D_push = 16'h0200 + 16'(i);
         tick();
      end
      check("ovf_rx_count", 16'(bif.rx_count), 16'd8);
      check("ovf_cnt_1",    16'(bif.ovf_cnt),  16'd1);
      check("ovf_head",     bif.rx_data,       16'h0200);
      // Full, push and read together: no drop, count stays 8.
      bif.D_push = 16'h0277;
      bif.rx_ready = 1'b1;
      tick();
      bif.rx_ready = 1'b0;
      check("fullrw_count", 16'(bif.rx_count), 16'd8);
      check("fullrw_ovf",   16'(bif.ovf_cnt),  16'd1);
      check("fullrw_head",  bif.rx_data,       16'h0201);
      // Broadcast pushes also count as drops; saturate at 255.
      for (int i = 0; i < 300; i++) begin
         bif.D_push = (i % 2 == 0) ? 16'h0233 : 16'hFF44;
         tick();
      end
      bif.push = 1'b0;
      check("ovf_sat",       16'(bif.ovf_cnt),  16'd255);
      check("ovf_sat_count", 16'(bif.rx_count), 16'd8);
      check("ovf_sat_head",  bif.rx_data,       16'h0201);

      // Pop with TX empty.
      bif.pop = 1'b1; tick(); bif.pop = 1'b0;
      check("popempty_err",   16'(bif.err),      16'b11);
      check("popempty_count", 16'(bif.tx_count), 16'd0);

      // Reset pulse mid-operation acts immediately; first write lands on the
      // first edge with reset released.
      #2;
      reset = 1'b0;
      bif.tx_valid = 1'b1;
      bif.tx_data  = 16'h0BEE;
      #1;
      check("rp_err",      16'(bif.err),      16'd0);
      check("rp_tx_count", 16'(bif.tx_count), 16'd0);
      check("rp_rx_count", 16'(bif.rx_count), 16'd0);
      check("rp_ovf",      16'(bif.ovf_cnt),  16'd0);
      check("rp_rx_valid", 16'(bif.rx_valid), 16'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      bif.tx_valid = 1'b0;
      check("rp_first_wr", 16'(bif.tx_count), 16'd1);
      check("rp_first_d",  bif.D_pop,         16'h0BEE);
      bif.pop = 1'b1; tick(); bif.pop = 1'b0;

      // Fill TX, write while full ignored, write+pop while full pops only.
      bif.tx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bif.tx_data = 16'h00A0 + 16'(i);
         tick();
      end
      check("full_ready", 16'(bif.tx_ready), 16'd0);
      check("full_count", 16'(bif.tx_count), 16'd8);
      bif.tx_data = 16'h00BB; tick();
      check("full_ign_count", 16'(bif.tx_count), 16'd8);
      bif.tx_data = 16'h00CC;
      bif.pop = 1'b1;
      tick();
      bif.tx_valid = 1'b0;
      check("full_rw_count", 16'(bif.tx_count), 16'd7);
      for (int i = 1; i < 8; i++) begin
         check("full_drain", bif.D_pop, 16'h00A0 + 16'(i));
         tick();
      end
      bif.pop = 1'b0;
      check("full_drained", 16'(bif.pndng), 16'd0);

      // 20 random host writes with concurrent random bus pops.
      writes = 0;
      q.delete();
      for (int cyc = 0; cyc < 400 && writes < 20; cyc++) begin
         d = 16'($urandom);
         bif.tx_valid = 1'b1;
         bif.tx_data  = d;
         bif.pop      = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         accept = (q.size() < 8);
         if (bif.pop) begin
            check("rnd_dpop", bif.D_pop, q[0]);
            void'(q.pop_front());
         end
         if (accept) begin
            q.push_back(d);
            writes++;
         end
         tick();
      end
      bif.tx_valid = 1'b0;
      check("rnd_writes", 16'(writes), 16'd20);
      check("rnd_count",  16'(bif.tx_count), 16'(q.size()));
      for (int n = 0; n < 20 && q.size() > 0; n++) begin
         bif.pop = 1'b1;
         check("rnd_drain", bif.D_pop, q[0]);
         void'(q.pop_front());
         tick();
      end
      bif.pop = 1'b0;
      check("rnd_end_count", 16'(bif.tx_count), 16'd0);
      check("rnd_end_err",   16'(bif.err),      16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
